// File: rtl/demux_frame_sequencer.sv
// Serialises one latched 8-bit frame onto the 1x8 demux (a_out/s_out), one enabled
// channel per beat in ascending order, with backpressure and a frame_done pulse.
//
// state | meaning
// IDLE  | waiting for a frame offer, in_ready high
// SHIFT | presenting beat for channel idx, advance on out_ready
// DONE  | one-cycle frame_done pulse, then back to IDLE
module demux_frame_sequencer #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  in_data,
  input  logic [N_CH-1:0]  in_mask,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a_out,
  output logic [SEL_W-1:0] s_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [N_CH-1:0]  data;
  logic [N_CH-1:0]  mask;
  logic [SEL_W-1:0] idx;

  logic [SEL_W-1:0] first_idx;
  logic [SEL_W-1:0] next_idx;
  logic             has_next;
  logic             accept;

  // Downward scans so the last hit is the lowest qualifying channel.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_mask[i]) first_idx = SEL_W'(i);
      if (mask[i] && (SEL_W'(i) > idx)) begin
        has_next = 1'b1;
        next_idx = SEL_W'(i);
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      mask  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data <= in_data;
            mask <= in_mask;
            if (in_mask != '0) begin
              idx   <= first_idx;
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (has_next) idx <= next_idx;
            else          state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is held low while reset is asserted, including the abort cycle.
  assign in_ready   = rst_n && (state == IDLE);
  assign out_valid  = rst_n && (state == SHIFT);
  assign frame_done = rst_n && (state == DONE);
  assign busy       = rst_n && (state != IDLE);
  assign a_out      = out_valid && data[idx];
  assign s_out      = out_valid ? idx : '0;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Bench for demux_frame_sequencer: directed scenarios plus random frames checked
// against an expected-beat queue built from each frame's data and mask.
module tb_demux_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic [7:0] in_mask;
  logic       in_valid;
  logic       in_ready;
  logic       a_out;
  logic [2:0] s_out;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  demux_frame_sequencer #(.N_CH(8), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_out      (a_out),
    .s_out      (s_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_ready);
    chk({tag, "_out_valid"}, 8'(out_valid), 8'h0);
    chk({tag, "_a_out"}, 8'(a_out), 8'h0);
    chk({tag, "_s_out"}, 8'(s_out), 8'h0);
    chk({tag, "_frame_done"}, 8'(frame_done), 8'h0);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
    chk({tag, "_in_ready"}, 8'(in_ready), 8'(exp_ready));
  endtask

  // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 3-cycle stall on first beat.
  // keep=1 leaves in_valid high with the next frame (nd/nm) offered once this one ends.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] m, input int mode,
                           input bit keep, input logic [7:0] nd, input logic [7:0] nm);
    logic [3:0] q[$];
    int guard;
    int stall;
    for (int ch = 0; ch < 8; ch++)
      if (m[ch]) q.push_back({d[ch], 3'(ch)});
    chk("idle_in_ready", 8'(in_ready), 8'h1);
    in_data   = d;
    in_mask   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    guard = 0;
    stall = 0;
    while (q.size() > 0) begin
      chk("beat_out_valid", 8'(out_valid), 8'h1);
      chk("beat_s_out", 8'(s_out), 8'(q[0][2:0]));
      chk("beat_a_out", 8'(a_out), 8'(q[0][3]));
      chk("beat_frame_done", 8'(frame_done), 8'h0);
      chk("beat_in_ready", 8'(in_ready), 8'h0);
      chk("beat_busy", 8'(busy), 8'h1);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (stall >= 3);
          if (stall < 3) stall++;
        end
      endcase
      if (out_ready) void'(q.pop_front());
      in_data  = 8'($urandom);
      in_mask  = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      if (guard > 64) begin
        tests++;
        failed++;
        $error("FAIL beat_timeout observed=%0d beats_left expected=0", q.size());
        break;
      end
    end
    chk("done_frame_done", 8'(frame_done), 8'h1);
    chk("done_out_valid", 8'(out_valid), 8'h0);
    chk("done_a_out", 8'(a_out), 8'h0);
    chk("done_s_out", 8'(s_out), 8'h0);
    chk("done_in_ready", 8'(in_ready), 8'h0);
    chk("done_busy", 8'(busy), 8'h1);
    out_ready = 1'($urandom_range(0, 1));
    in_valid  = keep;
    in_data   = keep ? nd : 8'($urandom);
    in_mask   = keep ? nm : 8'($urandom);
    @(negedge clk);
    chk_quiet("post", 1'b1);
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mask   = 8'h00;
    out_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      chk_quiet("reset", 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 8'(in_ready), 8'h1);
    chk("release_busy", 8'(busy), 8'h0);

    run_frame(8'hA5, 8'hFF, 0, 1'b0, 8'h00, 8'h00);
    run_frame(8'h80, 8'h81, 0, 1'b0, 8'h00, 8'h00);
    run_frame(8'h5A, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    run_frame(8'h0F, 8'h0C, 2, 1'b0, 8'h00, 8'h00);

    // Abort during beat s=3 of a full frame.
    in_data   = 8'hFF;
    in_mask   = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_pre_s_out", 8'(s_out), 8'(k));
      @(negedge clk);
    end
    chk("abort_s3_s_out", 8'(s_out), 8'h3);
    chk("abort_s3_out_valid", 8'(out_valid), 8'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("abort", 1'b0);
    @(negedge clk);
    chk_quiet("abort_hold", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_in_ready", 8'(in_ready), 8'h1);

    // Back-to-back: second frame accepted in the IDLE cycle after frame_done.
    run_frame(8'h3C, 8'h5A, 0, 1'b1, 8'hC3, 8'h0F);
    run_frame(8'hC3, 8'h0F, 0, 1'b0, 8'h00, 8'h00);

    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      logic [7:0] m;
      int idle;
      idle = $urandom_range(0, 2);
      for (int c = 0; c < idle; c++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_mask  = 8'($urandom);
        @(negedge clk);
        chk_quiet("rand_idle", 1'b1);
      end
      d = 8'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_frame(d, m, 1, 1'b0, 8'h00, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
